icache_way_array: RTL and testbench
===================================

Name: icache_way_array

Overview:
N-way set-associative instruction-cache storage array: per-way tag, valid and byte-enabled data RAMs, plus per-set replacement state. It performs a registered lookup (tag compare, hit way, hit line, victim way) one cycle after request, and accepts refill or invalidate writes. A sweep FSM clears all valid bits after reset or on a flush request. It sits between the ICache control FSM and the AXI refill path, generalising the single-way array to WAYS ways.

Parameters:
WAYS, 2, number of ways; power of two, 1..8
INDEX_W, 7, set index width; SETS = 2**INDEX_W
TAG_W, 20, tag width
WORD_OFF_W, 3, log2 words per line; WPL = 2**WORD_OFF_W, line = 32*WPL bits

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  pulse: invalidate all lines (starts sweep)
busy  out  1  sweep in progress; requests ignored
rd_en  in  1  lookup request
rd_index  in  INDEX_W  lookup set
rd_tag  in  TAG_W  lookup tag, sampled with rd_en
rsp_valid  out  1  lookup result valid (1 cycle after accepted rd_en)
hit  out  1  some valid way matched rd_tag
hit_way  out  WAYS  one-hot matching way; 0 on miss
hit_line  out  32*WPL  data of hit way; 0 on miss
victim_way  out  WAYS  one-hot way to refill for this set
wr_en  in  1  write request
wr_index  in  INDEX_W  write set
wr_way  in  WAYS  one-hot target way
wr_tag  in  TAG_W  tag written
wr_valid  in  1  valid bit written
wr_be  in  4*WPL  byte enables for wr_data, bit 4*w+b -> word w byte b
wr_data  in  32*WPL  line data

Behaviour:
- States: INIT, IDLE. reset -> INIT, sweep counter 0. INIT: each cycle clear valid[all ways][cnt] and rr_ptr[cnt]; at cnt=SETS-1 go IDLE next cycle. busy=1 exactly in INIT (SETS cycles). flush in IDLE -> INIT, cnt=0; flush during INIT restarts cnt at 0.
- Reset values: busy=1, rsp_valid=0, hit=0, hit_way=0, hit_line=0, victim_way=one-hot way0.
- Reset mid-operation: any in-flight lookup dropped (rsp_valid=0 next cycle), sweep restarts; data/tag RAM contents undefined, never reported hit since valid=0.
- Lookup: rd_en accepted only when busy=0. Cycle T accept; T+1 rsp_valid=1 for one cycle, hit/hit_way/hit_line/victim_way valid that cycle; back-to-back lookups every cycle, throughput 1. Non-accepted cycles: rsp_valid=0, other outputs hold last value.
- hit = OR over ways of (valid & tag==rd_tag). More than one match is a control error; hit_way then reports the lowest matching way.
- victim_way: lowest-index invalid way of the set; if all valid, rr_ptr[set] (log2(WAYS)-bit round-robin). WAYS=1: always 1.
- Write: wr_en accepted only when busy=0, takes effect at edge T. Writes tag:=wr_tag and valid:=wr_valid of wr_way, data bytes where wr_be=1. wr_be=0 with wr_valid=0 is a pure invalidate. wr_way must be one-hot; 0 means no write.
- Replacement update: on accepted write with wr_valid=1 and wr_way equal to rr_ptr[wr_index] (as one-hot), rr_ptr[wr_index] increments modulo WAYS; otherwise unchanged. Hits do not update rr_ptr.
- Collision: rd_en and wr_en same cycle, same index: lookup returns pre-write contents (read-first). Write at T, lookup at T+1 sees new contents.
- Tag/valid in distributed RAM or registers; data per way per word in block RAM with 4-bit byte write enable, synchronous read.

Test Plan:
- Reset (WAYS=2, INDEX_W=4): assert reset 1 cycle -> busy=1 for exactly 16 cycles, rsp_valid=0; rd_en during busy -> no rsp_valid.
- Refill way0 idx 3, tag 0x12345, wr_be all ones, data pattern; lookup idx 3 tag 0x12345 -> next cycle hit=1, hit_way=01, hit_line=pattern; tag 0x12346 -> hit=0, hit_way=00, victim_way=10.
- Fill both ways of idx 5 (way0 then way1 via victim_way) -> victim_way sequence 01,10, then 01 (rr_ptr=0); refill way0 -> victim_way=10.
- Partial byte write wr_be=0x000F to valid line -> only word0 replaced, other words unchanged on lookup.
- Same-cycle lookup and invalidate (wr_valid=0) on idx 3 -> that response hit=1; lookup next cycle hit=0.
- flush while lookups streaming -> busy=1 for 16 cycles, all subsequent lookups miss; reset asserted mid-sweep -> counter restarts, busy 16 more cycles.

Source files
------------

// File: rtl/icache_way_array_if.sv
// icache_way_array_if
//   Lookup and write bus between the ICache control FSM (master) and the
//   way array (slave).
//   Lookup: rd_en/rd_index/rd_tag in; rsp_valid/hit/hit_way/hit_line/victim_way out.
//   Write : wr_en/wr_index/wr_way/wr_tag/wr_valid/wr_be/wr_data in.
interface icache_way_array_if #(
    parameter int WAYS       = 2,
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 20,
    parameter int WORD_OFF_W = 3
);
    localparam int WPL    = 2**WORD_OFF_W;
    localparam int LINE_W = 32*WPL;
    localparam int BE_W   = 4*WPL;

    logic               rd_en;
    logic [INDEX_W-1:0] rd_index;
    logic [TAG_W-1:0]   rd_tag;
    logic               rsp_valid;
    logic               hit;
    logic [WAYS-1:0]    hit_way;
    logic [LINE_W-1:0]  hit_line;
    logic [WAYS-1:0]    victim_way;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [WAYS-1:0]    wr_way;
    logic [TAG_W-1:0]   wr_tag;
    logic               wr_valid;
    logic [BE_W-1:0]    wr_be;
    logic [LINE_W-1:0]  wr_data;

    modport master (
        output rd_en, rd_index, rd_tag,
        output wr_en, wr_index, wr_way, wr_tag, wr_valid, wr_be, wr_data,
        input  rsp_valid, hit, hit_way, hit_line, victim_way
    );

    modport slave (
        input  rd_en, rd_index, rd_tag,
        input  wr_en, wr_index, wr_way, wr_tag, wr_valid, wr_be, wr_data,
        output rsp_valid, hit, hit_way, hit_line, victim_way
    );
endinterface

// File: rtl/icache_way_array.sv
// icache_way_array
//   WAYS-way set-associative instruction-cache storage: per-way tag/valid
//   registers, per-way per-word byte-enabled data RAM, per-set round-robin
//   pointer. Lookup result is registered one cycle after an accepted rd_en.
//   Ports:
//     clk    : clock, all state on rising edge
//     reset  : synchronous active-high reset
//     flush  : pulse, restarts the valid-clearing sweep
//     busy   : sweep in progress, lookups and writes ignored
//     bus    : slave side of icache_way_array_if (lookup + write)
//
//   state | meaning
//   ------+----------------------------------------------------
//   INIT  | sweep: clear valid/rr_ptr of set cnt, busy=1
//   IDLE  | normal operation, lookups and writes accepted
module icache_way_array #(
    parameter int WAYS       = 2,
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 20,
    parameter int WORD_OFF_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    output logic busy,
    icache_way_array_if.slave bus
);
    localparam int SETS   = 2**INDEX_W;
    localparam int WPL    = 2**WORD_OFF_W;
    localparam int LINE_W = 32*WPL;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {INIT, IDLE} state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;

    logic [WAYS-1:0]    valid_q  [SETS];
    logic [TAG_W-1:0]   tag_q    [WAYS][SETS];
    logic [PTR_W-1:0]   rr_q     [SETS];
    logic [31:0]        data_mem [WAYS][WPL][SETS];
    logic [31:0]        rd_word_q[WAYS][WPL];

    logic               rd_acc, wr_acc;
    logic [WAYS-1:0]    match, hit_way_c, victim_c, wr_rr_oh;

    logic               rsp_q, hit_q;
    logic [WAYS-1:0]    hit_way_q, victim_q;
    logic [LINE_W-1:0]  hit_line_c;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (cnt_q == INDEX_W'(SETS-1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + INDEX_W'(1);
                end
            end
            IDLE: begin
                if (flush) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy   = (state_q == INIT);
    // A request in the reset cycle is dropped along with everything else.
    assign rd_acc = bus.rd_en & ~busy & ~reset;
    assign wr_acc = bus.wr_en & ~busy & ~reset;

    // ---------------- lookup (pre-write state: read-first) ----------------
    always_comb begin
        match     = '0;
        hit_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[bus.rd_index][w] && (tag_q[w][bus.rd_index] == bus.rd_tag);
        end
        // Descending scan so the lowest matching way wins.
        for (int w = WAYS-1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way_c    = '0;
                hit_way_c[w] = 1'b1;
            end
        end
    end

    always_comb begin
        victim_c = WAYS'(1) << rr_q[bus.rd_index];
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!valid_q[bus.rd_index][w]) begin
                victim_c    = '0;
                victim_c[w] = 1'b1;
            end
        end
    end

    // ---------------- tag / valid / replacement state ----------------
    assign wr_rr_oh = WAYS'(1) << rr_q[bus.wr_index];

    always_ff @(posedge clk) begin
        if (busy) begin
            valid_q[cnt_q] <= '0;
            rr_q[cnt_q]    <= '0;
        end else if (wr_acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.wr_way[w]) begin
                    tag_q[w][bus.wr_index]   <= bus.wr_tag;
                    valid_q[bus.wr_index][w] <= bus.wr_valid;
                end
            end
            if (WAYS > 1 && bus.wr_valid && bus.wr_way == wr_rr_oh) begin
                rr_q[bus.wr_index] <= rr_q[bus.wr_index] + PTR_W'(1);
            end
        end
    end

    // ---------------- data RAM: sync read, byte-enabled write ----------------
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            for (int i = 0; i < WPL; i++) begin
                if (rd_acc) begin
                    rd_word_q[w][i] <= data_mem[w][i][bus.rd_index];
                end
                for (int b = 0; b < 4; b++) begin
                    if (wr_acc && bus.wr_way[w] && bus.wr_be[4*i+b]) begin
                        data_mem[w][i][bus.wr_index][8*b +: 8] <= bus.wr_data[32*i+8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------- registered response ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q     <= 1'b0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= WAYS'(1);
        end else begin
            rsp_q <= rd_acc;
            if (rd_acc) begin
                hit_q     <= |match;
                hit_way_q <= hit_way_c;
                victim_q  <= victim_c;
            end
        end
    end

    // hit_way_q is zero on a miss, which also zeroes the line.
    always_comb begin
        hit_line_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_way_q[w]) begin
                for (int i = 0; i < WPL; i++) begin
                    hit_line_c[32*i +: 32] = hit_line_c[32*i +: 32] | rd_word_q[w][i];
                end
            end
        end
    end

    assign bus.rsp_valid  = rsp_q;
    assign bus.hit        = hit_q;
    assign bus.hit_way    = hit_way_q;
    assign bus.hit_line   = hit_line_c;
    assign bus.victim_way = victim_q;
endmodule

// File: tb/tb_icache_way_array.sv
module tb_icache_way_array;
    localparam int WAYS = 2, INDEX_W = 4, TAG_W = 20, WORD_OFF_W = 3;
    localparam int WPL = 8, LINE_W = 256, BE_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic busy;

    icache_way_array_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
                          .WORD_OFF_W(WORD_OFF_W)) bus ();

    icache_way_array #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
                       .WORD_OFF_W(WORD_OFF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [LINE_W-1:0] pat;
    logic [LINE_W-1:0] exp_line;
    logic [LINE_W-1:0] zero_line;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_en    = 1'b0;
        bus.rd_index = '0;
        bus.rd_tag   = '0;
        bus.wr_en    = 1'b0;
        bus.wr_index = '0;
        bus.wr_way   = '0;
        bus.wr_tag   = '0;
        bus.wr_valid = 1'b0;
        bus.wr_be    = '0;
        bus.wr_data  = '0;
    endtask

    task automatic lookup(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag);
        bus.rd_en    = 1'b1;
        bus.rd_index = idx;
        bus.rd_tag   = tag;
        tick();
        bus.rd_en    = 1'b0;
    endtask

    task automatic write_line(input logic [INDEX_W-1:0] idx, input logic [WAYS-1:0] way,
                              input logic [TAG_W-1:0] tag, input logic vld,
                              input logic [BE_W-1:0] be, input logic [LINE_W-1:0] data);
        bus.wr_en    = 1'b1;
        bus.wr_index = idx;
        bus.wr_way   = way;
        bus.wr_tag   = tag;
        bus.wr_valid = vld;
        bus.wr_be    = be;
        bus.wr_data  = data;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    // Counts consecutive busy samples starting at the current one (bounded)
    // and how many of them after the first showed rsp_valid.
    task automatic count_busy(output int n, output int rsp_seen);
        n = 0;
        rsp_seen = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            n++;
            if (i > 0 && bus.rsp_valid) rsp_seen++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n, rs;
        idle_inputs();
        reset = 1'b1;
        bus.rd_en = 1'b1;
        bus.rd_index = 4'd1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy got %b want 1", busy); end
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.hit !== 1'b0 || bus.hit_way !== 2'b00 ||
            bus.hit_line !== zero_line || bus.victim_way !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_outputs got rsp=%b hit=%b way=%b victim=%b line=%h want 0 0 00 01 0",
                     bus.rsp_valid, bus.hit, bus.hit_way, bus.victim_way, bus.hit_line);
        end
        count_busy(n, rs);
        bus.rd_en = 1'b0;
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL reset_busy_len got %0d want 16", n); end
        tests_run++;
        if (rs !== 0) begin tests_failed++; $display("FAIL reset_rd_during_busy got %0d rsp want 0", rs); end
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_no_late_rsp got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_refill();
        for (int w = 0; w < WPL; w++) pat[32*w +: 32] = 32'hC0DE_0000 | (32'h0101 * w);
        write_line(4'd3, 2'b01, 20'h12345, 1'b1, 32'hFFFF_FFFF, pat);
        lookup(4'd3, 20'h12345);
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 2'b01) begin
            tests_failed++;
            $display("FAIL refill_hit got rsp=%b hit=%b way=%b want 1 1 01", bus.rsp_valid, bus.hit, bus.hit_way);
        end
        tests_run++;
        if (bus.hit_line !== pat) begin tests_failed++; $display("FAIL refill_line got %h want %h", bus.hit_line, pat); end
        lookup(4'd3, 20'h12346);
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.hit_way !== 2'b00 ||
            bus.hit_line !== zero_line || bus.victim_way !== 2'b10) begin
            tests_failed++;
            $display("FAIL refill_miss got rsp=%b hit=%b way=%b victim=%b want 1 0 00 10",
                     bus.rsp_valid, bus.hit, bus.hit_way, bus.victim_way);
        end
    endtask

    task automatic test_round_robin();
        lookup(4'd5, 20'h0000A);
        tests_run++;
        if (bus.hit !== 1'b0 || bus.victim_way !== 2'b01) begin
            tests_failed++; $display("FAIL rr_victim0 got hit=%b victim=%b want 0 01", bus.hit, bus.victim_way);
        end
        write_line(4'd5, 2'b01, 20'h0000A, 1'b1, '1, {8{32'h1111_1111}});
        lookup(4'd5, 20'h0000B);
        tests_run++;
        if (bus.hit !== 1'b0 || bus.victim_way !== 2'b10) begin
            tests_failed++; $display("FAIL rr_victim1 got hit=%b victim=%b want 0 10", bus.hit, bus.victim_way);
        end
        write_line(4'd5, 2'b10, 20'h0000B, 1'b1, '1, {8{32'h2222_2222}});
        lookup(4'd5, 20'h0000C);
        tests_run++;
        if (bus.hit !== 1'b0 || bus.victim_way !== 2'b01) begin
            tests_failed++; $display("FAIL rr_victim_full got hit=%b victim=%b want 0 01", bus.hit, bus.victim_way);
        end
        write_line(4'd5, 2'b01, 20'h0000C, 1'b1, '1, {8{32'h3333_3333}});
        lookup(4'd5, 20'h0000D);
        tests_run++;
        if (bus.hit !== 1'b0 || bus.victim_way !== 2'b10) begin
            tests_failed++; $display("FAIL rr_victim_wrap got hit=%b victim=%b want 0 10", bus.hit, bus.victim_way);
        end
        lookup(4'd5, 20'h0000B);
        tests_run++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 2'b10 || bus.hit_line !== {8{32'h2222_2222}}) begin
            tests_failed++; $display("FAIL rr_hit_way1 got hit=%b way=%b line=%h want 1 10 2222..",
                                     bus.hit, bus.hit_way, bus.hit_line);
        end
    endtask

    task automatic test_back_to_back();
        bus.rd_en = 1'b1;
        bus.rd_index = 4'd5;
        bus.rd_tag = 20'h0000A;
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.victim_way !== 2'b10) begin
            tests_failed++; $display("FAIL b2b_0 got rsp=%b hit=%b victim=%b want 1 0 10", bus.rsp_valid, bus.hit, bus.victim_way);
        end
        bus.rd_tag = 20'h0000B;
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 2'b10) begin
            tests_failed++; $display("FAIL b2b_1 got rsp=%b hit=%b way=%b want 1 1 10", bus.rsp_valid, bus.hit, bus.hit_way);
        end
        bus.rd_tag = 20'h0000C;
        tick();
        bus.rd_en = 1'b0;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 2'b01 ||
            bus.hit_line !== {8{32'h3333_3333}}) begin
            tests_failed++; $display("FAIL b2b_2 got rsp=%b hit=%b way=%b line=%h want 1 1 01 3333..",
                                     bus.rsp_valid, bus.hit, bus.hit_way, bus.hit_line);
        end
        bus.rd_tag = 20'h0000D;
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.hit !== 1'b1 || bus.hit_way !== 2'b01 ||
            bus.hit_line !== {8{32'h3333_3333}}) begin
            tests_failed++; $display("FAIL b2b_hold got rsp=%b hit=%b way=%b want 0 1 01 (held)",
                                     bus.rsp_valid, bus.hit, bus.hit_way);
        end
    endtask

    task automatic test_partial_write();
        logic [LINE_W-1:0] junk;
        junk = {8{32'hFFFF_FFFF}};
        junk[31:0] = 32'hDEAD_BEEF;
        exp_line = pat;
        exp_line[31:0] = 32'hDEAD_BEEF;
        write_line(4'd3, 2'b01, 20'h12345, 1'b1, 32'h0000_000F, junk);
        lookup(4'd3, 20'h12345);
        tests_run++;
        if (bus.hit !== 1'b1 || bus.hit_line !== exp_line) begin
            tests_failed++; $display("FAIL partial_write got hit=%b line=%h want 1 %h", bus.hit, bus.hit_line, exp_line);
        end
    endtask

    task automatic test_collision();
        bus.rd_en    = 1'b1;
        bus.rd_index = 4'd3;
        bus.rd_tag   = 20'h12345;
        bus.wr_en    = 1'b1;
        bus.wr_index = 4'd3;
        bus.wr_way   = 2'b01;
        bus.wr_tag   = 20'h12345;
        bus.wr_valid = 1'b0;
        bus.wr_be    = '0;
        bus.wr_data  = '0;
        tick();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 2'b01 || bus.hit_line !== exp_line) begin
            tests_failed++; $display("FAIL collision_read_first got rsp=%b hit=%b way=%b want 1 1 01",
                                     bus.rsp_valid, bus.hit, bus.hit_way);
        end
        lookup(4'd3, 20'h12345);
        tests_run++;
        if (bus.hit !== 1'b0 || bus.hit_way !== 2'b00 || bus.hit_line !== zero_line || bus.victim_way !== 2'b01) begin
            tests_failed++; $display("FAIL collision_after got hit=%b way=%b victim=%b want 0 00 01",
                                     bus.hit, bus.hit_way, bus.victim_way);
        end
    endtask

    task automatic test_flush();
        int n, rs;
        bus.rd_en    = 1'b1;
        bus.rd_index = 4'd5;
        bus.rd_tag   = 20'h0000C;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b1) begin
            tests_failed++; $display("FAIL flush_last_lookup got rsp=%b hit=%b want 1 1", bus.rsp_valid, bus.hit);
        end
        count_busy(n, rs);
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL flush_busy_len got %0d want 16", n); end
        tests_run++;
        if (rs !== 0) begin tests_failed++; $display("FAIL flush_rd_during_busy got %0d rsp want 0", rs); end
        tick();
        bus.rd_en = 1'b0;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.hit !== 1'b0 || bus.hit_way !== 2'b00 || bus.victim_way !== 2'b01) begin
            tests_failed++; $display("FAIL flush_miss got rsp=%b hit=%b way=%b victim=%b want 1 0 00 01",
                                     bus.rsp_valid, bus.hit, bus.hit_way, bus.victim_way);
        end
        lookup(4'd5, 20'h0000B);
        tests_run++;
        if (bus.hit !== 1'b0) begin tests_failed++; $display("FAIL flush_miss_way1 got hit=%b want 0", bus.hit); end

        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n, rs);
        tests_run++;
        if (n !== 16) begin tests_failed++; $display("FAIL reset_mid_sweep_len got %0d want 16", n); end
    endtask

    initial begin
        zero_line = '0;
        pat = '0;
        exp_line = '0;
        idle_inputs();
        test_reset();
        test_refill();
        test_round_robin();
        test_back_to_back();
        test_partial_write();
        test_collision();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
